serial_accumulator: RTL and testbench

SERIAL_ACCUMULATOR -- requirements
Module: serial_accumulator

---
 rtl/acc_pkg.sv | 13 +
 rtl/rca.sv | 24 ++
 rtl/serial_accumulator.sv | 111 +++++++++++
 tb/tb_serial_accumulator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the serial accumulator.
package acc_pkg;

  localparam int DATA_W          = 4;
  localparam int MAX_OPS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder: s = A + B + cin, carry-out on cout.
module rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/serial_accumulator.sv
// Serial signed accumulator: adds/subtracts a stream of 4-bit operands,
// presents the wrapped sum with a sticky overflow flag and operand count.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; last result held on sum/ovf/op_count
// ACCUM | accepting operand beats (in_ready=1)
// DONE  | result presented (out_valid=1) until out_ready
module serial_accumulator
  import acc_pkg::*;
#(
  parameter int MAX_OPS = MAX_OPS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              ovf,
  output logic [3:0]        op_count
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OPS);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] s_add;
  logic              cout_unused;
  logic              beat;
  logic              ovf_beat;
  logic [3:0]        cnt_next;
  logic              final_beat;

  // Subtraction is A + ~B + 1, so the inverted operand and the carry-in
  // both come from in_sub.
  assign b_eff = in_sub ? ~in_data : in_data;

  rca #(.W(DATA_W)) u_rca (
    .A    (acc),
    .B    (b_eff),
    .cin  (in_sub),
    .s    (s_add),
    .cout (cout_unused)
  );

  // Per-beat qualifiers: acceptance, signed overflow, saturating count
  always_comb begin
    beat       = in_valid && in_ready;
    ovf_beat   = (acc[DATA_W-1] == b_eff[DATA_W-1]) && (s_add[DATA_W-1] != acc[DATA_W-1]);
    cnt_next   = (op_count == MAX_CNT) ? op_count : op_count + 4'd1;
    final_beat = in_last || (cnt_next == MAX_CNT);
  end

  // FSM with registered handshake outputs and accumulator datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      op_count  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            ovf      <= 1'b0;
            op_count <= '0;
            in_ready <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc      <= s_add;
            ovf      <= ovf | ovf_beat;
            op_count <= cnt_next;
            if (final_beat) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Result comes straight from the register, never from the adder
  assign sum = acc;

endmodule

// File: tb/tb_serial_accumulator.sv
// Bench for serial_accumulator: table of accumulation runs plus hand-written
// sequences for saturation, back-pressure and reset corner cases.
module tb_serial_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_sub;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] sum;
  logic       ovf;
  logic [3:0] op_count;

  typedef struct {
    int         n;
    logic [15:0] d;
    logic [3:0]  s;
    logic [3:0]  e_sum;
    logic        e_ovf;
    logic [3:0]  e_cnt;
  } run_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  run_t runs [9];
  exp_t q [$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;

  serial_accumulator #(.MAX_OPS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .ovf       (ovf),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_result(input string tag, input exp_t x);
    chk({tag, "_sum"}, 8'(sum), 8'(x.sum));
    chk({tag, "_ovf"}, 8'(ovf), 8'(x.ovf));
    chk({tag, "_cnt"}, 8'(op_count), 8'(x.cnt));
  endtask

  task automatic pop_result(input string tag, output exp_t x);
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_queue: got empty scoreboard expected entry", tag);
      x = '0;
    end else begin
      x = q.pop_front();
    end
  endtask

  task automatic do_run(input run_t r, input bit start_mid, input bit bubble);
    exp_t x;
    q.push_back('{r.e_sum, r.e_ovf, r.e_cnt});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("ready_accum", 8'(in_ready), 8'd1);
    for (int i = 0; i < r.n; i++) begin
      if (bubble && i == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = r.d[4*i +: 4];
      in_sub   = r.s[i];
      in_last  = (i == r.n - 1);
      if (start_mid && i == 1) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_out_valid", 8'(out_valid), 8'd1);
    chk("done_in_ready", 8'(in_ready), 8'd0);
    pop_result("run", x);
    chk_result("run", x);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("idle_out_valid", 8'(out_valid), 8'd0);
    chk_result("idle_hold", x);
  endtask

  initial begin
    runs[0] = '{2, 16'h0031, 4'b0000, 4'h4, 1'b0, 4'd2};
    runs[1] = '{2, 16'h005D, 4'b0000, 4'h2, 1'b0, 4'd2};
    runs[2] = '{2, 16'h00B2, 4'b0000, 4'hD, 1'b0, 4'd2};
    runs[3] = '{2, 16'h0017, 4'b0000, 4'h8, 1'b1, 4'd2};
    runs[4] = '{1, 16'h0001, 4'b0000, 4'h1, 1'b0, 4'd1};
    runs[5] = '{2, 16'h0052, 4'b0010, 4'hD, 1'b0, 4'd2};
    runs[6] = '{2, 16'h0018, 4'b0010, 4'h7, 1'b1, 4'd2};
    runs[7] = '{3, 16'h0643, 4'b0011, 4'hF, 1'b0, 4'd3};
    runs[8] = '{2, 16'h0018, 4'b0001, 4'h9, 1'b1, 4'd2};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_result("reset", '{4'h0, 1'b0, 4'd0});
    chk("reset_in_ready", 8'(in_ready), 8'd0);
    chk("reset_out_valid", 8'(out_valid), 8'd0);
    rst_n = 1'b1;

    // in_valid while idle must not be consumed
    in_valid = 1'b1; in_data = 4'h5; in_last = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ignore_ready", 8'(in_ready), 8'd0);
    chk("idle_ignore_valid", 8'(out_valid), 8'd0);
    chk("idle_ignore_cnt", 8'(op_count), 8'd0);
    in_valid = 1'b0; in_last = 1'b0;

    for (int k = 0; k < 9; k++) do_run(runs[k], k == 1, k == 3);

    // Saturation at MAX_OPS with back-pressure and start during DONE
    q.push_back('{4'h8, 1'b1, 4'd8});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    in_valid = 1'b1; in_data = 4'h1; in_sub = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("sat_ready_%0d", i), 8'(in_ready), 8'(i < 8));
      if (i == 8) chk("sat_out_valid", 8'(out_valid), 8'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop_result("sat", e);
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 8'(out_valid), 8'd1);
      chk_result("hold", e);
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("hold_after_start", 8'(out_valid), 8'd1);
    chk_result("hold_after_start", e);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("sat_idle_out_valid", 8'(out_valid), 8'd0);
    @(negedge clk);
    chk("sat_idle_in_ready", 8'(in_ready), 8'd0);

    // Reset mid-run after three beats
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    in_valid = 1'b1; in_data = 4'h3; in_sub = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_result("midrst", '{4'h0, 1'b0, 4'd0});
    chk("midrst_in_ready", 8'(in_ready), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_out_valid", 8'(out_valid), 8'd0);
    end
    chk("postrst_in_ready", 8'(in_ready), 8'd0);

    // First start honoured on the first edge after release
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    q.push_back('{4'h5, 1'b0, 4'd1});
    @(negedge clk) start = 1'b0;
    chk("first_start_ready", 8'(in_ready), 8'd1);
    in_valid = 1'b1; in_data = 4'h5; in_sub = 1'b0; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("first_start_out_valid", 8'(out_valid), 8'd1);
    pop_result("first", e);
    chk_result("first", e);
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
    chk("first_idle", 8'(out_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
